// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory, buffers returned words with their PC and hands
// them downstream on a valid/ready handshake. A taken branch flushes the
// buffer, drops any in-flight response and restarts fetch at the target.
//
// Ports
//   clk_in, reset_in                  clock, async active-high reset
//   imem_req_o / imem_addr_o          registered memory request and address
//   imem_ack_in / imem_rdata_in       request accepted, instruction word
//   branch_taken_in/branch_target_in  single-cycle redirect strobe and target
//   instr_valid_o / instr_ready_in    downstream handshake on buffer head
//   instr_o / pc_o                    head instruction and its PC
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk_in,
  input  logic            reset_in,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_target_in,
  output logic            instr_valid_o,
  input  logic            instr_ready_in,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0]   pc_mem_q   [DEPTH];
  logic [XLEN-1:0]   data_mem_q [DEPTH];

  logic              ack_c;
  logic              pop_c;
  logic              push_c;
  logic              flush_c;
  logic [XLEN-1:0]   target_c;
  logic [XLEN-1:0]   pc_inc_c;
  logic [CNT_W-1:0]  cnt_pop_c;
  logic [CNT_W-1:0]  cnt_push_c;

  // Handshake qualifiers and occupancy after this cycle's pop/push
  assign ack_c      = req_q & imem_ack_in;
  assign pop_c      = instr_valid_o & instr_ready_in;
  assign target_c   = branch_target_in & ~XLEN'(3);
  assign pc_inc_c   = pc_q + XLEN'(4);
  assign cnt_pop_c  = count_q - CNT_W'(pop_c);
  assign cnt_push_c = cnt_pop_c + CNT_W'(1);

  // Next-state, PC and request address
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push_c  = 1'b0;
    flush_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (branch_taken_in) begin
          flush_c = 1'b1;
          pc_d    = target_c;
          addr_d  = target_c;
          state_d = FETCH;
        end else if (cnt_pop_c < CNT_W'(DEPTH)) begin
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (branch_taken_in) begin
          flush_c = 1'b1;
          pc_d    = target_c;
          if (ack_c) begin
            // Returned word belongs to the wrong path; restart at once
            addr_d  = target_c;
            state_d = FETCH;
          end else begin
            // Request must stay up at the old address until it is acked
            state_d = KILL;
          end
        end else if (ack_c) begin
          push_c = 1'b1;
          pc_d   = pc_inc_c;
          if (cnt_push_c < CNT_W'(DEPTH)) begin
            addr_d  = pc_inc_c;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end

      KILL: begin
        if (branch_taken_in) begin
          flush_c = 1'b1;
          pc_d    = target_c;
          if (ack_c) begin
            addr_d  = target_c;
            state_d = FETCH;
          end
        end else if (ack_c) begin
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d = (state_d != IDLE);
  end

  // Buffer bookkeeping; a flush overrides both push and pop
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_c) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = cnt_pop_c + CNT_W'(push_c);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    end
  end

  // Control state registers
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Buffer storage, cleared on reset so the head reads zero
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push_c) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      data_mem_q[wr_ptr_q] <= imem_rdata_in;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_mem_q[rd_ptr_q];
  assign pc_o          = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, randomized run against a
// queue-based reference model, and a PC wrap / async reset sequence on a
// second instance with RESET_PC at the top of the address space.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst, ack, br, ready;
  logic [31:0] rdata, tgt;
  logic        req, valid;
  logic [31:0] addr, instr, pc;

  logic        rst2, ack2;
  logic        br2, ready2;
  logic [31:0] rdata2, tgt2;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk_in(clk), .reset_in(rst),
    .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_in(ack), .imem_rdata_in(rdata),
    .branch_taken_in(br), .branch_target_in(tgt),
    .instr_valid_o(valid), .instr_ready_in(ready),
    .instr_o(instr), .pc_o(pc)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_dut_wrap (
    .clk_in(clk), .reset_in(rst2),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_in(ack2), .imem_rdata_in(rdata2),
    .branch_taken_in(br2), .branch_target_in(tgt2),
    .instr_valid_o(valid2), .instr_ready_in(ready2),
    .instr_o(instr2), .pc_o(pc2)
  );

  assign rdata2 = ~addr2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic [31:0] rd, input logic rdy,
                              input logic b, input logic [31:0] t, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.ack = a; v.rdata = rd; v.ready = rdy; v.br = b; v.tgt = t;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  // Reference model: in-order queue of {pc, word} plus the request view
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic        m_req, m_kill;
  logic [31:0] m_addr, m_pc;

  task automatic model_reset();
    mq.delete();
    m_req  = 1'b0;
    m_kill = 1'b0;
    m_addr = 32'h0;
    m_pc   = 32'h0;
  endtask

  // Predicts the state after the coming clock edge from this cycle's inputs
  task automatic model_step(input logic a, input logic [31:0] rd, input logic rdy,
                            input logic b, input logic [31:0] t);
    logic acked;
    ent_t e;
    acked = m_req && a;
    if (b) begin
      mq.delete();
      m_pc = t & 32'hFFFF_FFFC;
      if (m_req && !acked) begin
        m_kill = 1'b1;
      end else begin
        m_kill = 1'b0;
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (acked) begin
        if (!m_kill) begin
          e.pc = m_addr;
          e.instr = rd;
          mq.push_back(e);
          m_pc = m_addr + 32'd4;
        end
        m_kill = 1'b0;
        if (mq.size() < DEPTH) begin
          m_req  = 1'b1;
          m_addr = m_pc;
        end else begin
          m_req = 1'b0;
        end
      end else if (!m_req && mq.size() < DEPTH) begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask

  vec_t vecs[28];

  initial begin
    //                ack rdata          rdy br tgt           req addr          v  instr          pc
    vecs[0]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,         32'h0);
    vecs[1]  = mk(1'b1, 32'h1000_0000, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,         32'h0);
    vecs[2]  = mk(1'b1, 32'h1000_0004, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h1000_0000, 32'h0);
    vecs[3]  = mk(1'b1, 32'h1000_0008, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h1000_0004, 32'h4);
    vecs[4]  = mk(1'b1, 32'h1000_000C, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h1000_0008, 32'h8);
    vecs[5]  = mk(1'b1, 32'hEEEE_0000, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h1000_0008, 32'h8);
    vecs[6]  = mk(1'b1, 32'hEEEE_0001, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h1000_0008, 32'h8);
    vecs[7]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h1000_000C, 32'hC);
    vecs[8]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h1000_000C, 32'hC);
    vecs[9]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h1000_000C, 32'hC);
    vecs[10] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h1000_000C, 32'hC);
    vecs[11] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h1000_000C, 32'hC);
    vecs[12] = mk(1'b1, 32'h1000_0010, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h1000_000C, 32'hC);
    vecs[13] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h100, 1'b1, 32'h14,  1'b1, 32'h1000_0010, 32'h10);
    vecs[14] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 32'h0,         32'h0);
    vecs[15] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 32'h0,         32'h0);
    vecs[16] = mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 32'h0,         32'h0);
    vecs[17] = mk(1'b1, 32'h2000_0100, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,         32'h0);
    vecs[18] = mk(1'b1, 32'h2000_0104, 1'b1, 1'b1, 32'h203, 1'b1, 32'h104, 1'b1, 32'h2000_0100, 32'h100);
    vecs[19] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,         32'h0);
    vecs[20] = mk(1'b1, 32'h3000_0200, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,         32'h0);
    vecs[21] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h300, 1'b1, 32'h204, 1'b1, 32'h3000_0200, 32'h200);
    vecs[22] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h400, 1'b1, 32'h204, 1'b0, 32'h0,         32'h0);
    vecs[23] = mk(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0,         32'h0);
    vecs[24] = mk(1'b1, 32'h4000_0400, 1'b0, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h0,         32'h0);
    vecs[25] = mk(1'b1, 32'h4000_0404, 1'b0, 1'b0, 32'h0,   1'b1, 32'h404, 1'b1, 32'h4000_0400, 32'h400);
    vecs[26] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h500, 1'b0, 32'h404, 1'b1, 32'h4000_0400, 32'h400);
    vecs[27] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h500, 1'b0, 32'h0,         32'h0);

    rst = 1'b1; ack = 1'b0; rdata = '0; br = 1'b0; tgt = '0; ready = 1'b0;
    rst2 = 1'b1; ack2 = 1'b0; br2 = 1'b0; tgt2 = '0; ready2 = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_req",   {31'b0, req},   32'h0);
    chk("reset_addr",  addr,           32'h0);
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_instr", instr,          32'h0);
    chk("reset_pc",    pc,             32'h0);
    rst = 1'b0;

    // Directed table: inputs for the coming edge, outputs as of the last edge
    for (int i = 0; i < 28; i++) begin
      ack = vecs[i].ack; rdata = vecs[i].rdata; ready = vecs[i].ready;
      br = vecs[i].br; tgt = vecs[i].tgt;
      #1;
      chk($sformatf("row%0d_req", i),   {31'b0, req},   {31'b0, vecs[i].e_req});
      chk($sformatf("row%0d_addr", i),  addr,           vecs[i].e_addr);
      chk($sformatf("row%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("row%0d_instr", i), instr, vecs[i].e_instr);
        chk($sformatf("row%0d_pc", i),    pc,    vecs[i].e_pc);
      end
      @(negedge clk);
    end

    // Randomized run against the reference model
    rst = 1'b1; ack = 1'b0; br = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_req",   {31'b0, req},   {31'b0, m_req});
      chk("rnd_addr",  addr,           m_addr);
      chk("rnd_valid", {31'b0, valid}, {31'b0, (mq.size() != 0)});
      if (mq.size() != 0) begin
        chk("rnd_instr", instr, mq[0].instr);
        chk("rnd_pc",    pc,    mq[0].pc);
      end
      ack   = ($urandom_range(0, 3) != 0);
      rdata = $urandom;
      ready = ($urandom_range(0, 4) > 1);
      br    = ($urandom_range(0, 11) == 0);
      tgt   = $urandom;
      model_step(ack, rdata, ready, br, tgt);
      @(negedge clk);
    end
    ack = 1'b0; br = 1'b0; ready = 1'b0;

    // PC wrap at the top of the address space, then async reset mid-wait
    chk("wrap_reset_req",  {31'b0, req2}, 32'h0);
    chk("wrap_reset_addr", addr2,         32'hFFFF_FFFC);
    rst2 = 1'b0;
    ack2 = 1'b1;
    @(negedge clk);
    chk("wrap_first_req",  {31'b0, req2}, 32'h1);
    chk("wrap_first_addr", addr2,         32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_next_addr",  addr2,          32'h0);
    chk("wrap_valid",      {31'b0, valid2}, 32'h1);
    chk("wrap_head_pc",    pc2,            32'hFFFF_FFFC);
    chk("wrap_head_instr", instr2,         32'h0000_0003);
    ack2 = 1'b0;
    @(negedge clk);
    chk("wrap_wait_req",   {31'b0, req2},   32'h1);
    chk("wrap_wait_addr",  addr2,           32'h0);
    chk("wrap_wait_valid", {31'b0, valid2}, 32'h0);
    #2 rst2 = 1'b1;
    #1;
    chk("async_rst_req",   {31'b0, req2},   32'h0);
    chk("async_rst_addr",  addr2,           32'hFFFF_FFFC);
    chk("async_rst_valid", {31'b0, valid2}, 32'h0);
    chk("async_rst_instr", instr2,          32'h0);
    chk("async_rst_pc",    pc2,             32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
